// File: rtl/j1_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the J1 I/O bus.
// CPU pushes bytes into a FIFO; an FSM serialises them on tx.
module j1_io_uart_tx #(
  parameter logic [15:0] BASE_ADDR   = 16'h6000,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_din,
  output logic [15:0] io_dout,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Bus decode
  logic       hit;
  logic [1:0] off;
  logic       wr_data;
  logic       wr_stat;
  logic       wr_div;
  logic       unused_addr0;

  assign hit = (io_addr[15:3] == BASE_ADDR[15:3])
            && (io_addr[15:14] != 2'b00);
  assign off = io_addr[2:1];
  assign wr_data = io_wr && hit && (off == 2'd0);
  assign wr_stat = io_wr && hit && (off == 2'd1);
  assign wr_div  = io_wr && hit && (off == 2'd2);
  assign unused_addr0 = io_addr[0];

  // FIFO state
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic [FIFO_AW:0]   cnt_d;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;

  // Transmitter state
  state_e      state_q;
  logic [2:0]  bit_q;
  logic [15:0] baud_q;
  logic [15:0] div_l_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        baud_end;

  // Registers
  logic        ovf_q;
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic [15:0] status;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign baud_end = (baud_q == div_l_q - 16'd1);

  // The FSM pops on leaving IDLE or at the end of a stop bit.
  assign pop  = !empty && ((state_q == S_IDLE)
             || ((state_q == S_STOP) && baud_end));
  assign push = wr_data && (!full || pop);
  assign drop = wr_data && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (wr_div) begin
      div_d = (io_din < 16'd2) ? 16'd2 : io_din;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= io_din[7:0];
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      div_q  <= DEFAULT_DIV;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
      div_q <= div_d;
      // A drop in the same cycle as a clear leaves overflow set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (wr_stat && io_din[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      baud_q  <= '0;
      div_l_q <= DEFAULT_DIV;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            div_l_q <= div_q;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              div_l_q <= div_q;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status = '0;
    status[0] = (state_q != S_IDLE);
    status[1] = full;
    status[2] = empty;
    status[3] = ovf_q;
    status[8+FIFO_AW:8] = cnt_q;
  end

  always_comb begin
    io_dout = '0;
    if (io_rd && hit) begin
      case (off)
        2'd1:    io_dout = status;
        2'd2:    io_dout = div_q;
        default: io_dout = '0;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_j1_io_uart_tx.sv
// Directed bench for j1_io_uart_tx.
// Each task drives one scenario and checks inline.
module tb_j1_io_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_din = '0;
  logic [15:0] io_dout;
  logic        tx;
  logic        tx_busy;

  int total = 0;
  int bad = 0;

  localparam logic [15:0] A_DATA = 16'h6000;
  localparam logic [15:0] A_STAT = 16'h6002;
  localparam logic [15:0] A_DIV  = 16'h6004;
  localparam logic [15:0] A_RSV  = 16'h6006;

  j1_io_uart_tx dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_din    (io_din),
    .io_dout   (io_dout),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_wr = 1'b1;
    io_addr = a;
    io_din = d;
    @(posedge clk);
    #1;
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_rd = 1'b1;
    io_addr = a;
    #1;
    d = io_dout;
    @(posedge clk);
    #1;
    io_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL rst_tx got=%b exp=1", tx);
    end
    total++;
    if (tx_busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", tx_busy);
    end
    rd(A_STAT, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL rst_status got=%h exp=0004", d);
    end
    rd(A_DIV, d);
    total++;
    if (d !== 16'd434) begin
      bad++; $display("FAIL rst_div got=%0d exp=434", d);
    end
    // Reset in the middle of a frame of zeros
    wr(A_DIV, 16'd4);
    wr(A_DATA, 16'h0000);
    repeat (10) @(negedge clk);
    total++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      bad++; $display("FAIL mid_pre got=%b%b exp=01", tx, tx_busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      bad++; $display("FAIL mid_rst got=%b%b exp=10", tx, tx_busy);
    end
    rd(A_STAT, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL mid_status got=%h exp=0004", d);
    end
    rd(A_DIV, d);
    total++;
    if (d !== 16'd434) begin
      bad++; $display("FAIL mid_div got=%0d exp=434", d);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [9:0]  f;
    logic [15:0] d;
    f = {1'b1, 8'hA5, 1'b0};
    wr(A_DIV, 16'd4);
    wr(A_DATA, 16'h00A5);
    @(negedge clk);
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL single_pre got=%b exp=1", tx);
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      total++;
      if (tx !== f[j/4]) begin
        bad++; $display("FAIL single_bit c=%0d got=%b exp=%b", j, tx, f[j/4]);
      end
    end
    rd(A_STAT, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL single_status got=%h exp=0004", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1;
    logic [9:0] f2;
    logic       e;
    f1 = {1'b1, 8'h00, 1'b0};
    f2 = {1'b1, 8'hFF, 1'b0};
    wr(A_DIV, 16'd2);
    wr(A_DATA, 16'h0000);
    wr(A_DATA, 16'h00FF);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      e = (j < 20) ? f1[j/2] : f2[(j-20)/2];
      total++;
      if (tx !== e) begin
        bad++; $display("FAIL b2b_bit c=%0d got=%b exp=%b", j, tx, e);
      end
    end
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%b%b exp=10", tx, tx_busy);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    wr(A_DIV, 16'd1000);
    for (int i = 0; i < 18; i++) begin
      wr(A_DATA, 16'(i));
    end
    rd(A_STAT, d);
    total++;
    if (d !== 16'h100B) begin
      bad++; $display("FAIL ovf_status got=%h exp=100b", d);
    end
    total++;
    if (tx !== 1'b0) begin
      bad++; $display("FAIL ovf_tx got=%b exp=0", tx);
    end
    wr(A_STAT, 16'h0008);
    rd(A_STAT, d);
    total++;
    if (d !== 16'h1003) begin
      bad++; $display("FAIL ovf_clear got=%h exp=1003", d);
    end
    do_reset();
  endtask

  task automatic test_decode();
    logic [15:0] d;
    wr(16'h6010, 16'h0055);
    wr(16'h0100, 16'h0055);
    @(negedge clk);
    total++;
    if (tx_busy !== 1'b0) begin
      bad++; $display("FAIL dec_busy got=%b exp=0", tx_busy);
    end
    rd(A_STAT, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL dec_status got=%h exp=0004", d);
    end
    rd(16'h7000, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL dec_unmapped got=%h exp=0000", d);
    end
    rd(16'h6003, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL dec_a0 got=%h exp=0004", d);
    end
    rd(A_DATA, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL dec_data_rd got=%h exp=0000", d);
    end
    wr(A_RSV, 16'hFFFF);
    rd(A_RSV, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL dec_rsv got=%h exp=0000", d);
    end
    rd(A_DIV, d);
    total++;
    if (d !== 16'd434) begin
      bad++; $display("FAIL dec_div got=%0d exp=434", d);
    end
    @(negedge clk);
    io_addr = A_STAT;
    io_rd = 1'b0;
    #1;
    total++;
    if (io_dout !== 16'h0000) begin
      bad++; $display("FAIL dec_nostrobe got=%h exp=0000", io_dout);
    end
  endtask

  task automatic test_div();
    logic [15:0] d;
    logic        e;
    wr(A_DIV, 16'd0);
    rd(A_DIV, d);
    total++;
    if (d !== 16'd2) begin
      bad++; $display("FAIL div_clamp0 got=%0d exp=2", d);
    end
    wr(A_DIV, 16'd1);
    rd(A_DIV, d);
    total++;
    if (d !== 16'd2) begin
      bad++; $display("FAIL div_clamp1 got=%0d exp=2", d);
    end
    wr(A_DIV, 16'd3);
    wr(A_DATA, 16'h0000);
    wr(A_DATA, 16'h0000);
    wr(A_DIV, 16'd5);
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      e = (j < 27) ? 1'b0 : (j < 30) ? 1'b1 : (j < 75) ? 1'b0 : 1'b1;
      total++;
      if (tx !== e) begin
        bad++; $display("FAIL div_bit c=%0d got=%b exp=%b", j, tx, e);
      end
      total++;
      if (tx_busy !== (j < 80)) begin
        bad++; $display("FAIL div_busy c=%0d got=%b exp=%b", j, tx_busy, j < 80);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_decode();
    test_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
